// File: rtl/bus_trace_monitor.sv
// Bus trace monitor: snoops data-bus strobes, filters by programmable address windows,
// and buffers timestamped accesses in a FIFO drained through a valid/ready port.
module bus_trace_monitor #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    localparam int MASK_W    = DATA_WIDTH / 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int FILL_W    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic [DATA_WIDTH-1:0]        bus_data,
    input  logic [MASK_W-1:0]            bus_mask,
    input  logic                         bus_wr,
    input  logic                         bus_rd,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] win_base,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] win_mask,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic                         cap_wr,
    input  logic                         cap_rd,
    input  logic                         wrap_mode,
    input  logic                         clear,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [ADDR_WIDTH-1:0]        trace_addr,
    output logic [DATA_WIDTH-1:0]        trace_data,
    output logic [MASK_W-1:0]            trace_mask,
    output logic [CH_W-1:0]              trace_ch,
    output logic                         trace_is_wr,
    output logic [TS_WIDTH-1:0]          trace_ts,
    output logic [FILL_W-1:0]            fill,
    output logic [15:0]                  dropped,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_W-1:0]     mask;
        logic [CH_W-1:0]       ch;
        logic                  is_wr;
        logic [TS_WIDTH-1:0]   ts;
    } entry_t;

    logic [TS_WIDTH-1:0] r_ts;
    logic                r_prev_wr;
    logic                r_prev_rd;
    logic                r_ev_valid;
    entry_t              r_ev;
    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic                r_valid;
    entry_t              r_head;
    logic [15:0]         r_dropped;
    logic                r_overflow;

    logic                w_wr_edge;
    logic                w_rd_edge;
    logic                w_hit;
    logic [CH_W-1:0]     w_hit_ch;
    logic                w_event;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;
    logic                w_ovw;
    logic                w_drop;
    logic                w_wr_en;
    logic [PTR_W-1:0]    w_wr_ptr_nx;
    logic [PTR_W-1:0]    w_rd_ptr_nx;
    logic [FILL_W-1:0]   w_fill_nx;
    entry_t              w_head_nx;

    assign w_wr_edge = bus_wr & ~r_prev_wr;
    assign w_rd_edge = bus_rd & ~r_prev_rd;

    // Scan from the top so the lowest hitting channel is the last assignment and wins.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_en[i] &&
                ((bus_addr & win_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 (win_base[i*ADDR_WIDTH +: ADDR_WIDTH] & win_mask[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_W'(i);
            end
        end
    end

    assign w_event = w_hit && ((w_wr_edge && cap_wr) || (!w_wr_edge && w_rd_edge && cap_rd));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ts       <= '0;
            r_prev_wr  <= 1'b0;
            r_prev_rd  <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev       <= '0;
        end else begin
            r_ts       <= r_ts + TS_WIDTH'(1);
            r_prev_wr  <= bus_wr;
            r_prev_rd  <= bus_rd;
            r_ev_valid <= w_event && !clear;
            r_ev       <= '{addr: bus_addr, data: bus_data, mask: bus_mask,
                            ch: w_hit_ch, is_wr: w_wr_edge, ts: r_ts};
        end
    end

    assign w_pop    = r_valid && trace_ready;
    assign w_full   = (r_fill == FILL_W'(DEPTH));
    assign w_accept = r_ev_valid && (!w_full || w_pop);
    assign w_ovw    = r_ev_valid && w_full && !w_pop && wrap_mode;
    assign w_drop   = r_ev_valid && w_full && !w_pop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_ptr_nx = r_wr_ptr;
        w_rd_ptr_nx = r_rd_ptr;
        w_fill_nx   = r_fill;
        if (clear) begin
            w_wr_ptr_nx = '0;
            w_rd_ptr_nx = '0;
            w_fill_nx   = '0;
        end else begin
            w_wr_en = w_accept || w_ovw;
            if (w_wr_en) w_wr_ptr_nx = r_wr_ptr + PTR_W'(1);
            if (w_pop || w_ovw) w_rd_ptr_nx = r_rd_ptr + PTR_W'(1);
            if (w_accept && !w_pop) w_fill_nx = r_fill + FILL_W'(1);
            else if (!w_accept && w_pop) w_fill_nx = r_fill - FILL_W'(1);
        end
    end

    // The slot being written this cycle may become the new head; forward it directly.
    always_comb begin
        w_head_nx = r_mem[w_rd_ptr_nx];
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_nx)) w_head_nx = r_ev;
        if (w_fill_nx == '0) w_head_nx = '0;
    end

    // NOTE: the storage array carries no reset; fill and pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) r_mem[r_wr_ptr] <= r_ev;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_dropped  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nx;
            r_rd_ptr <= w_rd_ptr_nx;
            r_fill   <= w_fill_nx;
            r_valid  <= (w_fill_nx != '0);
            r_head   <= w_head_nx;
            if (clear) begin
                r_dropped  <= '0;
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid = r_valid;
    assign trace_addr  = r_head.addr;
    assign trace_data  = r_head.data;
    assign trace_mask  = r_head.mask;
    assign trace_ch    = r_head.ch;
    assign trace_is_wr = r_head.is_wr;
    assign trace_ts    = r_head.ts;
    assign fill        = r_fill;
    assign dropped     = r_dropped;
    assign overflow    = r_overflow;

endmodule
